// File: rtl/ysyx_25030085_core_seq_if.sv
// Memory-side bus for the sequential core. It carries the instruction-fetch
// and data-memory request/response signals.
//   master (core)  : drives ifu_req_valid, ifu_addr, lsu_req_valid
//   slave (memory) : drives ifu_req_ready, ifu_rsp_valid, ifu_rsp_data,
//                    lsu_req_ready, lsu_rsp_valid
// Handshake rule: a request transfers on a cycle where valid and ready are
// both 1. Once raised, valid stays high until that cycle. A response is a
// single-cycle pulse. It is taken only while the core is in its matching
// wait state, and it is ignored in every other state.
interface ysyx_25030085_core_seq_if;
  logic        ifu_req_valid;
  logic        ifu_req_ready;
  logic [31:0] ifu_addr;
  logic        ifu_rsp_valid;
  logic [31:0] ifu_rsp_data;
  logic        lsu_req_valid;
  logic        lsu_req_ready;
  logic        lsu_rsp_valid;

  modport master (
    output ifu_req_valid, ifu_addr, lsu_req_valid,
    input  ifu_req_ready, ifu_rsp_valid, ifu_rsp_data, lsu_req_ready, lsu_rsp_valid
  );

  modport slave (
    input  ifu_req_valid, ifu_addr, lsu_req_valid,
    output ifu_req_ready, ifu_rsp_valid, ifu_rsp_data, lsu_req_ready, lsu_rsp_valid
  );
endinterface

// File: rtl/ysyx_25030085_core_seq.sv
// Multi-cycle sequential core controller. Each instruction steps through
// FETCH -> IWAIT -> EXEC -> (MEM -> MWAIT ->) WB. The core stops in HALT on
// any of these: ebreak, an illegal instruction, a misaligned next PC, or a
// memory wait timeout.
// Ports:
//   clk, rst        clock and synchronous active-high reset
//   bus             fetch/data-memory handshakes (master side)
//   dec_*           decoder controls for the latched instruction
//   dec_imm/rs1_val immediate value and rs1 operand
//   inst            latched instruction word
//   rf_we           register-file write strobe (WB only)
//   pc, instret     current PC and retired-instruction count
//   halt, halt_code halted flag and cause (1 ebreak, 2 illegal/misaligned,
//                   3 timeout)
//   dbg_state       FSM state encoding
//                   (0 FETCH, 1 IWAIT, 2 EXEC, 3 MEM, 4 MWAIT, 5 WB, 6 HALT)
module ysyx_25030085_core_seq #(
  parameter logic [31:0] RESET_PC = 32'h8000_0000,
  parameter logic [7:0]  TIMEOUT  = 8'd255
) (
  input  logic                             clk,
  input  logic                             rst,
  ysyx_25030085_core_seq_if.master         bus,
  input  logic                             dec_mem_read,
  input  logic                             dec_mem_write,
  input  logic                             dec_reg_write,
  input  logic                             dec_branch,
  input  logic                             dec_ebreak,
  input  logic                             dec_invalid,
  input  logic [1:0]                       dec_jump,
  input  logic [31:0]                      dec_imm,
  input  logic [31:0]                      rs1_val,
  output logic [31:0]                      inst,
  output logic                             rf_we,
  output logic [31:0]                      pc,
  output logic                             halt,
  output logic [1:0]                       halt_code,
  output logic [31:0]                      instret,
  output logic [2:0]                       dbg_state
);

  typedef enum logic [2:0] {
    S_FETCH = 3'd0,
    S_IWAIT = 3'd1,
    S_EXEC  = 3'd2,
    S_MEM   = 3'd3,
    S_MWAIT = 3'd4,
    S_WB    = 3'd5,
    S_HALT  = 3'd6
  } state_t;

  // The counter holds (cycles already spent in the wait state) - 1 at the
  // start of each cycle. The last allowed cycle is therefore TIMEOUT-1.
  localparam logic [7:0] WAIT_LAST = TIMEOUT - 8'd1;

  state_t      state, state_next;
  logic [1:0]  halt_code_next;
  logic [7:0]  wait_cnt;
  logic [31:0] next_pc;
  logic        pc_aligned;
  logic        waiting;
  logic        timed_out;

  // Next-PC selection. Jalr clears bit 0 before the alignment check.
  always_comb begin
    next_pc = pc + 32'd4;
    if (dec_jump == 2'b01 || dec_branch) begin
      next_pc = pc + dec_imm;
    end else if (dec_jump == 2'b10) begin
      next_pc = (rs1_val + dec_imm) & ~32'h1;
    end
  end

  assign pc_aligned = (next_pc[1:0] == 2'b00);
  assign waiting    = (state == S_FETCH) || (state == S_IWAIT) ||
                      (state == S_MEM)   || (state == S_MWAIT);
  assign timed_out  = waiting && (wait_cnt == WAIT_LAST);

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= S_FETCH;
    end else begin
      state <= state_next;
    end
  end

  // Next-state logic. A handshake that completes on the last allowed cycle
  // takes priority over the timeout.
  always_comb begin
    state_next     = state;
    halt_code_next = halt_code;
    case (state)
      S_FETCH: begin
        if (bus.ifu_req_ready) state_next = S_IWAIT;
        else if (timed_out) begin state_next = S_HALT; halt_code_next = 2'd3; end
      end
      S_IWAIT: begin
        if (bus.ifu_rsp_valid) state_next = S_EXEC;
        else if (timed_out) begin state_next = S_HALT; halt_code_next = 2'd3; end
      end
      S_EXEC: begin
        if (dec_ebreak) begin
          state_next = S_HALT; halt_code_next = 2'd1;
        end else if (dec_invalid || dec_jump == 2'b11) begin
          state_next = S_HALT; halt_code_next = 2'd2;
        end else if (dec_mem_read || dec_mem_write) begin
          state_next = S_MEM;
        end else begin
          state_next = S_WB;
        end
      end
      S_MEM: begin
        if (bus.lsu_req_ready) state_next = S_MWAIT;
        else if (timed_out) begin state_next = S_HALT; halt_code_next = 2'd3; end
      end
      S_MWAIT: begin
        if (bus.lsu_rsp_valid) state_next = S_WB;
        else if (timed_out) begin state_next = S_HALT; halt_code_next = 2'd3; end
      end
      S_WB: begin
        if (pc_aligned) state_next = S_FETCH;
        else begin state_next = S_HALT; halt_code_next = 2'd2; end
      end
      default: state_next = S_HALT;
    endcase
  end

  // Output decode
  always_comb begin
    bus.ifu_req_valid = (state == S_FETCH);
    bus.lsu_req_valid = (state == S_MEM);
    rf_we             = (state == S_WB) && dec_reg_write && pc_aligned;
    halt              = (state == S_HALT);
  end

  assign bus.ifu_addr = pc;
  assign dbg_state    = state;

  // Datapath registers
  always_ff @(posedge clk) begin
    if (rst) begin
      pc        <= RESET_PC;
      inst      <= 32'd0;
      instret   <= 32'd0;
      wait_cnt  <= 8'd0;
      halt_code <= 2'd0;
    end else begin
      halt_code <= halt_code_next;
      if (state == S_IWAIT && bus.ifu_rsp_valid) begin
        inst <= bus.ifu_rsp_data;
      end
      if (state == S_WB && pc_aligned) begin
        pc      <= next_pc;
        instret <= instret + 32'd1;
      end
      // Clear on every state change so each wait state starts from zero.
      if (state_next != state) begin
        wait_cnt <= 8'd0;
      end else if (waiting) begin
        wait_cnt <= wait_cnt + 8'd1;
      end
    end
  end

endmodule

// File: tb/tb_ysyx_25030085_core_seq.sv
module tb_ysyx_25030085_core_seq;

  localparam logic [31:0] RESET_PC = 32'h8000_0000;
  localparam int          TIMEOUT  = 255;

  localparam logic [2:0] ST_FETCH = 3'd0;
  localparam logic [2:0] ST_IWAIT = 3'd1;
  localparam logic [2:0] ST_EXEC  = 3'd2;
  localparam logic [2:0] ST_MEM   = 3'd3;
  localparam logic [2:0] ST_MWAIT = 3'd4;
  localparam logic [2:0] ST_WB    = 3'd5;
  localparam logic [2:0] ST_HALT  = 3'd6;

  // Clock and reset
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  ysyx_25030085_core_seq_if bus ();

  logic        dec_mem_read, dec_mem_write, dec_reg_write;
  logic        dec_branch, dec_ebreak, dec_invalid;
  logic [1:0]  dec_jump;
  logic [31:0] dec_imm, rs1_val;
  logic [31:0] inst, pc, instret;
  logic        rf_we, halt;
  logic [1:0]  halt_code;
  logic [2:0]  dbg_state;

  ysyx_25030085_core_seq #(.RESET_PC(RESET_PC), .TIMEOUT(8'(TIMEOUT))) dut (
    .clk           (clk),
    .rst           (rst),
    .bus           (bus.master),
    .dec_mem_read  (dec_mem_read),
    .dec_mem_write (dec_mem_write),
    .dec_reg_write (dec_reg_write),
    .dec_branch    (dec_branch),
    .dec_ebreak    (dec_ebreak),
    .dec_invalid   (dec_invalid),
    .dec_jump      (dec_jump),
    .dec_imm       (dec_imm),
    .rs1_val       (rs1_val),
    .inst          (inst),
    .rf_we         (rf_we),
    .pc            (pc),
    .halt          (halt),
    .halt_code     (halt_code),
    .instret       (instret),
    .dbg_state     (dbg_state)
  );

  int total = 0;
  int bad   = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Outputs are sampled 1ns after the rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clr_dec();
    dec_mem_read = 0; dec_mem_write = 0; dec_reg_write = 0;
    dec_branch = 0; dec_ebreak = 0; dec_invalid = 0;
    dec_jump = 2'b00; dec_imm = 32'd0; rs1_val = 32'd0;
  endtask

  task automatic clr_bus();
    bus.ifu_req_ready = 0; bus.ifu_rsp_valid = 0; bus.ifu_rsp_data = 32'd0;
    bus.lsu_req_ready = 0; bus.lsu_rsp_valid = 0;
  endtask

  task automatic do_reset();
    rst = 1;
    tick();
    rst = 0;
    clr_dec();
    clr_bus();
  endtask

  // Zero-wait fetch that starts in FETCH and ends in EXEC.
  task automatic fetch(input logic [31:0] word);
    bus.ifu_req_ready = 1;
    tick();
    bus.ifu_req_ready = 0;
    bus.ifu_rsp_valid = 1;
    bus.ifu_rsp_data  = word;
    tick();
    bus.ifu_rsp_valid = 0;
  endtask

  initial begin : stim
    int n;
    clr_dec();
    clr_bus();
    rst = 1;
    tick();
    tick();
    rst = 0;

    // Reset state
    chk("rst_state", 32'(dbg_state), 32'(ST_FETCH));
    chk("rst_pc", pc, RESET_PC);
    chk("rst_inst", inst, 32'd0);
    chk("rst_instret", instret, 32'd0);
    chk("rst_halt", {30'd0, halt, rf_we}, 32'd0);
    chk("rst_halt_code", 32'(halt_code), 32'd0);
    chk("rst_ifu_valid", 32'(bus.ifu_req_valid), 32'd1);
    chk("rst_lsu_valid", 32'(bus.lsu_req_valid), 32'd0);
    chk("rst_ifu_addr", bus.ifu_addr, RESET_PC);

    // Test 1: addi x1,x0,5. Cycle 1 is FETCH.
    bus.ifu_req_ready = 1;
    chk("t1_c1_rf_we", 32'(rf_we), 32'd0);
    tick();
    bus.ifu_req_ready = 0;
    bus.ifu_rsp_valid = 1;
    bus.ifu_rsp_data  = 32'h0050_0093;
    chk("t1_c2_state", 32'(dbg_state), 32'(ST_IWAIT));
    chk("t1_c2_ifu_valid", 32'(bus.ifu_req_valid), 32'd0);
    chk("t1_c2_rf_we", 32'(rf_we), 32'd0);
    tick();
    bus.ifu_rsp_valid = 0;
    dec_reg_write = 1;
    dec_imm = 32'd5;
    chk("t1_c3_inst", inst, 32'h0050_0093);
    chk("t1_c3_rf_we", 32'(rf_we), 32'd0);
    tick();
    chk("t1_c4_state", 32'(dbg_state), 32'(ST_WB));
    chk("t1_c4_rf_we", 32'(rf_we), 32'd1);
    tick();
    chk("t1_c5_rf_we", 32'(rf_we), 32'd0);
    chk("t1_pc", pc, 32'h8000_0004);
    chk("t1_instret", instret, 32'd1);
    chk("t1_ifu_valid", 32'(bus.ifu_req_valid), 32'd1);
    clr_dec();

    // Taken branch from 0x8000_0004 with an immediate of 0x10.
    fetch(32'h0000_0863);
    dec_branch = 1;
    dec_imm = 32'h10;
    tick();
    tick();
    chk("br_pc", pc, 32'h8000_0014);
    chk("br_instret", instret, 32'd2);
    clr_dec();

    // Aligned jalr. The sum 0x8000_0301 has bit 0 cleared.
    fetch(32'h0010_80e7);
    dec_jump = 2'b10;
    rs1_val = 32'h8000_0300;
    dec_imm = 32'd1;
    dec_reg_write = 1;
    tick();
    chk("jalr_ok_rf_we", 32'(rf_we), 32'd1);
    tick();
    chk("jalr_ok_pc", pc, 32'h8000_0300);
    clr_dec();

    // jal with a negative offset: 0x8000_0300 - 0x100.
    fetch(32'hf01f_f0ef);
    dec_jump = 2'b01;
    dec_imm = 32'hffff_ff00;
    tick();
    tick();
    chk("jal_pc", pc, 32'h8000_0200);
    chk("jal_instret", instret, 32'd4);
    clr_dec();

    // Test 2: jalr to 0x8000_0102 is misaligned, so the core halts with code 2.
    do_reset();
    fetch(32'h0020_80e7);
    dec_jump = 2'b10;
    rs1_val = 32'h8000_0101;
    dec_imm = 32'd2;
    dec_reg_write = 1;
    tick();
    chk("t2_wb_rf_we", 32'(rf_we), 32'd0);
    tick();
    chk("t2_halt", 32'(halt), 32'd1);
    chk("t2_halt_code", 32'(halt_code), 32'd2);
    chk("t2_pc", pc, RESET_PC);
    chk("t2_instret", instret, 32'd0);
    bus.ifu_req_ready = 1;
    tick();
    tick();
    chk("t2_absorb_state", 32'(dbg_state), 32'(ST_HALT));
    chk("t2_absorb_reqs", {30'd0, bus.ifu_req_valid, bus.lsu_req_valid}, 32'd0);
    bus.ifu_req_ready = 0;
    clr_dec();

    // Test 3: lw with lsu_req_ready raised on the 4th MEM cycle.
    do_reset();
    chk("t3_reset_from_halt", 32'(halt), 32'd0);
    fetch(32'h0000_a083);
    dec_mem_read = 1;
    dec_reg_write = 1;
    tick();
    bus.lsu_rsp_valid = 1;  // not in MWAIT, so the core must ignore it
    chk("t3_m1_valid", 32'(bus.lsu_req_valid), 32'd1);
    tick();
    bus.lsu_rsp_valid = 0;
    chk("t3_m2_state", 32'(dbg_state), 32'(ST_MEM));
    chk("t3_m2_valid", 32'(bus.lsu_req_valid), 32'd1);
    tick();
    chk("t3_m3_valid", 32'(bus.lsu_req_valid), 32'd1);
    tick();
    chk("t3_m4_valid", 32'(bus.lsu_req_valid), 32'd1);
    bus.lsu_req_ready = 1;
    tick();
    bus.lsu_req_ready = 0;
    chk("t3_mwait_state", 32'(dbg_state), 32'(ST_MWAIT));
    chk("t3_mwait_valid", 32'(bus.lsu_req_valid), 32'd0);
    tick();
    chk("t3_mwait_hold", 32'(dbg_state), 32'(ST_MWAIT));
    bus.lsu_rsp_valid = 1;
    tick();
    bus.lsu_rsp_valid = 0;
    chk("t3_wb_state", 32'(dbg_state), 32'(ST_WB));
    chk("t3_wb_rf_we", 32'(rf_we), 32'd1);
    tick();
    chk("t3_instret", instret, 32'd1);
    chk("t3_pc", pc, 32'h8000_0004);
    clr_dec();

    // Test 4: fetch response never arrives.
    do_reset();
    bus.ifu_req_ready = 1;
    tick();
    bus.ifu_req_ready = 0;
    n = 0;
    while (dbg_state == ST_IWAIT && n < 400) begin
      n++;
      tick();
    end
    chk("t4_iwait_cycles", 32'(n), 32'(TIMEOUT));
    chk("t4_halt", 32'(halt), 32'd1);
    chk("t4_halt_code", 32'(halt_code), 32'd3);

    // Test 5: ebreak and invalid together. ebreak has priority.
    do_reset();
    fetch(32'h0010_0073);
    dec_ebreak = 1;
    dec_invalid = 1;
    dec_reg_write = 1;
    chk("t5_exec_rf_we", 32'(rf_we), 32'd0);
    tick();
    chk("t5_halt_code", 32'(halt_code), 32'd1);
    chk("t5_halt_rf_we", 32'(rf_we), 32'd0);
    tick();
    chk("t5_halt_rf_we2", 32'(rf_we), 32'd0);
    clr_dec();

    // Test 6: reset in MWAIT, then a stale lsu response.
    do_reset();
    fetch(32'h0011_2023);
    dec_mem_write = 1;
    bus.lsu_req_ready = 1;
    tick();
    tick();
    bus.lsu_req_ready = 0;
    chk("t6_in_mwait", 32'(dbg_state), 32'(ST_MWAIT));
    rst = 1;
    tick();
    rst = 0;
    clr_dec();
    bus.lsu_rsp_valid = 1;
    chk("t6_state", 32'(dbg_state), 32'(ST_FETCH));
    chk("t6_pc", pc, RESET_PC);
    tick();
    bus.lsu_rsp_valid = 0;
    chk("t6_stale_state", 32'(dbg_state), 32'(ST_FETCH));
    chk("t6_stale_instret", instret, 32'd0);
    chk("t6_stale_rf_we", 32'(rf_we), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/ysyx_25030085_core_seq.md
YSYX_25030085_CORE_SEQ -- requirements
Module: ysyx_25030085_core_seq

Interface
REQ-001 SHALL have parameter RESET_PC, default 32'h8000_0000, the PC value loaded on reset.
REQ-002 SHALL have parameter TIMEOUT, default 8'd255, the maximum number of wait cycles on any memory handshake.
REQ-003 clk  in  1  single clock; all state updates on posedge.
REQ-004 rst  in  1  reset, synchronous, active-high.
REQ-005 ifu_req_valid  out  1  instruction fetch request.
REQ-006 ifu_req_ready  in  1  fetch request accepted.
REQ-007 ifu_addr  out  32  fetch address; always equals pc.
REQ-008 ifu_rsp_valid / ifu_rsp_data  in  1/32  fetch response and instruction word.
REQ-009 inst  out  32  latched instruction, fed to the decoder.
REQ-010 dec_mem_read, dec_mem_write, dec_reg_write, dec_branch, dec_ebreak, dec_invalid  in  1 each  decoder controls (dec_branch = branch taken).
REQ-011 dec_jump  in  2  01=jal, 10=jalr, 00=none, 11=reserved.
REQ-012 dec_imm, rs1_val  in  32 each  immediate and rs1 operand.
REQ-013 lsu_req_valid  out  1; lsu_req_ready  in  1; lsu_rsp_valid  in  1  data-memory handshake.
REQ-014 rf_we  out  1  register-file write strobe.
REQ-015 pc  out  32  current PC.
REQ-016 halt  out  1; halt_code  out  2  0=none, 1=ebreak, 2=illegal/misaligned, 3=timeout.
REQ-017 instret  out  32  count of retired instructions.

Function
REQ-018 SHALL implement states FETCH, IWAIT, EXEC, MEM, MWAIT, WB, HALT.
REQ-019 FETCH: SHALL assert ifu_req_valid; on ifu_req_ready go to IWAIT; valid SHALL NOT drop before ready.
REQ-020 IWAIT: on ifu_rsp_valid SHALL latch ifu_rsp_data into inst and go to EXEC.
REQ-021 ifu_rsp_valid / lsu_rsp_valid outside IWAIT / MWAIT SHALL be ignored.
REQ-022 EXEC transitions, evaluated in priority order:
- dec_ebreak -> HALT, code 1.
- dec_invalid or dec_jump==11 -> HALT, code 2.
- dec_mem_read or dec_mem_write -> MEM.
- otherwise -> WB.
REQ-023 MEM: SHALL assert lsu_req_valid until lsu_req_ready, then go to MWAIT; MWAIT: on lsu_rsp_valid go to WB. This applies to both loads and stores.
REQ-024 WB lasts one cycle: rf_we = dec_reg_write, pc <= next_pc, instret <= instret+1 (wraps modulo 2^32), then FETCH.
REQ-025 next_pc SHALL be selected as follows:
- dec_jump==01 or dec_branch: pc+dec_imm.
- dec_jump==10: (rs1_val+dec_imm) & ~32'h1.
- otherwise: pc+4.
All arithmetic is 32-bit, wrapping.
REQ-026 If next_pc[1:0]!=0 in WB: SHALL go to HALT, code 2, with pc and instret unchanged and rf_we=0.
REQ-027 A wait counter SHALL clear on entry to FETCH, IWAIT, MEM and MWAIT and increment each cycle spent in those states; reaching TIMEOUT SHALL go to HALT, code 3.
REQ-028 HALT is absorbing: halt=1, all request outputs 0, rf_we=0; only rst exits.
REQ-029 rf_we, ifu_req_valid and lsu_req_valid SHALL be 0 in every state not listed for them above.
REQ-030 Minimum latency with 0-wait memory SHALL be 4 cycles per non-memory instruction and 6 per load/store.

Reset
REQ-031 On rst: state=FETCH, pc=RESET_PC, inst=0, instret=0, wait counter=0, halt=0, halt_code=0, rf_we=0, lsu_req_valid=0.
REQ-032 rst asserted mid-operation (any state, including HALT) SHALL take effect next edge; responses pending from before rst SHALL be ignored per REQ-021.
REQ-033 ifu_req_valid SHALL be 1 in the first cycle after rst deasserts.

Verification
REQ-034 Test 1:
- Stimulus: addi x1,x0,5 at 0x8000_0000, ready and rsp each 1 cycle.
- Required: rf_we pulses once in cycle 4; pc=0x8000_0004; instret=1.
REQ-035 Test 2:
- Stimulus: jalr with rs1_val=0x8000_0101, dec_imm=2.
- Required: pc=0x8000_0102, which is misaligned, so HALT with code 2 and pc unchanged.
REQ-036 Test 3:
- Stimulus: lw with lsu_req_ready delayed 3 cycles.
- Required: lsu_req_valid held for 4 cycles; WB follows the lsu_rsp_valid cycle; instret increments.
REQ-037 Test 4:
- Stimulus: ifu_rsp_valid never asserted.
- Required: HALT with code 3 after exactly TIMEOUT IWAIT cycles.
REQ-038 Test 5:
- Stimulus: dec_ebreak=1 and dec_invalid=1 together in EXEC.
- Required: halt_code=1; rf_we never asserts.
REQ-039 Test 6:
- Stimulus: rst pulsed in MWAIT, with a stale lsu_rsp_valid the next cycle.
- Required: state=FETCH, pc=RESET_PC, stale response ignored.
